edge_propagator_arbiter: RTL
============================

Name: edge_propagator_arbiter

Overview:
- Shares one edge-propagator channel (level valid out, synchronized ack back) among NumReq local event sources.
- Latches single-cycle event pulses, picks one requester round-robin, and runs a four-phase valid/ack handshake on the channel.
- Drives an ID that the receive side uses to demultiplex events.
- Sits on the TX clock side. The far-side receiver returns ack asynchronously, so this block resynchronizes it.

Parameters:
- NumReq, 4, number of requesters (>=2).
- SyncStages, 2, flip-flop stages on chan_ack_i (>=2).
- IdWidth, $clog2(NumReq), width of chan_id_o (derived, not overridden).
- TimeoutCycles, 1024, handshake watchdog limit (used only with the optional feature).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset, active-high.
- req_i  in  NumReq  single-cycle event pulse per requester.
- clear_i  in  1  clears sticky overflow_o and timeout_o.
- pend_o  out  NumReq  event latched, not yet launched.
- grant_o  out  NumReq  one-cycle pulse when a requester's event is launched.
- overflow_o  out  NumReq  sticky: event arrived while the same requester was already pending.
- chan_valid_o  out  1  level valid to the edge-propagator channel.
- chan_id_o  out  IdWidth  ID of the event in flight.
- chan_ack_i  in  1  ack from the far side, asynchronous to clk_i.
- busy_o  out  1  handshake in progress (state != IDLE).
- timeout_o  out  1  sticky watchdog flag.

Behaviour:
- Clocking and reset:
  - Single clock domain. Reset is synchronous and active-high.
  - On rst_i: all outputs 0, FSM in IDLE, pending/overflow/timeout cleared, sync chain cleared.
  - Round-robin pointer reset so requester 0 has top priority.
  - Reset mid-handshake drops chan_valid_o to 0 next cycle. The receiver completes on its own.
- Ack synchronization:
  - ack_s is chan_ack_i after SyncStages flops. Only ack_s is used internally.
- Pending latch:
  - req_i[i]=1 sets pend[i] on the next edge.
  - If pend[i] is already 1 and is not being cleared by a launch that cycle, overflow_o[i] is set; the event is merged.
  - If req_i[i] coincides with the launch of i, pend[i] stays 1 (the new event is kept) and no overflow is flagged.
- FSM:
  - IDLE: if any pend bit is set, pick the first set bit at or after pointer, wrapping at NumReq-1 to 0. On the edge:
    - clear that pend bit, set chan_id_o to the index, set chan_valid_o=1, pulse grant_o[index] for one cycle;
    - set pointer to index+1 mod NumReq;
    - go to REQ.
  - REQ: chan_valid_o=1, chan_id_o held. When ack_s=1, set chan_valid_o=0 and go to REL.
  - REL: chan_valid_o=0, chan_id_o held. When ack_s=0, go to IDLE.
- Timing:
  - Latency from req_i to chan_valid_o rise is 2 cycles when IDLE and no competitor wins.
  - Minimum low time on chan_valid_o between events is 2 cycles (REL exit plus IDLE).
- Outputs and clear:
  - chan_id_o is stable from the valid rise until the IDLE re-entry. It changes only on launch.
  - busy_o=1 in REQ and REL.
  - clear_i clears overflow_o and timeout_o. A set condition in the same cycle wins over clear.
- Events are never lost except when merged, which is flagged by overflow_o.

Optional Feature:
- Macro: EDGE_PROPAGATOR_ARBITER_TIMEOUT_EN.
- With the macro defined:
  - a cycle counter resets on entry to REQ and to REL, and counts while in either state;
  - on reaching TimeoutCycles it sets timeout_o (sticky) and saturates;
  - the FSM does not abort; it keeps waiting for ack.
- Without the macro: no counter logic; timeout_o is tied to 0.

Test Plan:
- Loopback: chan_ack_i = chan_valid_o delayed 3 cycles. Pulse req_i=4'b0001 at cycle 0 -> chan_valid_o rises at cycle 2, chan_id_o=0, grant_o=4'b0001 at cycle 2. busy_o returns to 0 after ack_s falls. overflow_o=0.
- Simultaneous: req_i=4'b1111 in one cycle -> chan_id_o sequence 0,1,2,3. Exactly 4 grant pulses, pend_o=0 at end.
- Round-robin fairness: after serving 0, assert req_i=4'b0011 while IDLE -> ID 1 is served before ID 0.
- Overflow: req_i[2] pulsed twice while requester 3 holds the channel -> overflow_o=4'b0100, single launch with ID 2. clear_i pulse -> overflow_o=0.
- Same-cycle relaunch: req_i[1] on the cycle grant_o[1] fires -> pend_o[1]=1 afterwards, second launch of ID 1, no overflow.
- Timeout (macro on, TimeoutCycles=16): chan_ack_i held at 0 -> timeout_o=1 at 16 cycles after the REQ entry, chan_valid_o stays 1. Releasing ack completes normally. Reset mid-REQ -> chan_valid_o=0 on the next cycle.

Source files
------------

// File: rtl/edge_propagator_arbiter.sv
// edge_propagator_arbiter: round-robin arbiter driving a four-phase valid/ack edge-propagator channel.
// Define EDGE_PROPAGATOR_ARBITER_TIMEOUT_EN to build the handshake watchdog (timeout_o); otherwise timeout_o is 0.
module edge_propagator_arbiter #(
  parameter int NumReq        = 4,
  parameter int SyncStages    = 2,
  parameter int IdWidth       = $clog2(NumReq),
  parameter int TimeoutCycles = 1024
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NumReq-1:0]  req_i,
  input  logic               clear_i,
  output logic [NumReq-1:0]  pend_o,
  output logic [NumReq-1:0]  grant_o,
  output logic [NumReq-1:0]  overflow_o,
  output logic               chan_valid_o,
  output logic [IdWidth-1:0] chan_id_o,
  input  logic               chan_ack_i,
  output logic               busy_o,
  output logic               timeout_o
);
  typedef enum logic [1:0] {IDLE, REQ, REL} state_e;
  state_e                state_q;
  logic [SyncStages-1:0] sync_q;
  logic [NumReq-1:0]     pend_q, ovf_q, grant_q, pend_d, ovf_d, launch_oh;
  logic [IdWidth-1:0]    ptr_q, id_q, sel, ptr_d, idx;
  logic                  valid_q, ack_s, any, launch;

  // first pending requester at or after the pointer, wrapping
  always_comb begin
    sel = '0;
    any = 1'b0;
    idx = '0;
    for (int k = 0; k < NumReq; k++) begin
      idx = IdWidth'((int'(ptr_q) + k) % NumReq);
      if (!any && pend_q[idx]) begin
        any = 1'b1;
        sel = idx;
      end
    end
  end

  assign ack_s     = sync_q[SyncStages-1];
  assign launch    = (state_q == IDLE) && any;
  assign launch_oh = {{(NumReq-1){1'b0}}, launch} << sel;
  assign pend_d    = (pend_q & ~launch_oh) | req_i;
  assign ovf_d     = (ovf_q & ~{NumReq{clear_i}}) | (req_i & pend_q & ~launch_oh);
  assign ptr_d     = (int'(sel) == NumReq - 1) ? '0 : sel + 1'b1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      sync_q  <= '0;
      pend_q  <= '0;
      ovf_q   <= '0;
      grant_q <= '0;
      ptr_q   <= '0;
      id_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SyncStages-2:0], chan_ack_i};
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      grant_q <= launch_oh;
      case (state_q)
        IDLE: if (launch) begin
          state_q <= REQ;
          valid_q <= 1'b1;
          id_q    <= sel;
          ptr_q   <= ptr_d;
        end
        REQ: if (ack_s) begin
          state_q <= REL;
          valid_q <= 1'b0;
        end
        REL: if (!ack_s) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign pend_o       = pend_q;
  assign grant_o      = grant_q;
  assign overflow_o   = ovf_q;
  assign chan_valid_o = valid_q;
  assign chan_id_o    = id_q;
  assign busy_o       = state_q != IDLE;

`ifdef EDGE_PROPAGATOR_ARBITER_TIMEOUT_EN
  localparam int CntW = $clog2(TimeoutCycles + 1);
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            tmo_q;
  // restart on every state change (ack_s flips the state exactly when it differs from "in REL")
  assign cnt_d = (state_q == IDLE || ack_s != (state_q == REL)) ? '0 :
                 (cnt_q == CntW'(TimeoutCycles)) ? cnt_q : cnt_q + 1'b1;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tmo_q <= (cnt_d == CntW'(TimeoutCycles)) | (tmo_q & ~clear_i);
    end
  end
  assign timeout_o = tmo_q;
`else
  assign timeout_o = TimeoutCycles < 0;
`endif
endmodule
